// File: rtl/axis_frame_arbiter.sv
// Two-source AXI-Stream packet arbiter (round-robin at TLAST granularity) with a registered master slice.
// Optional per-source packet counters are enabled by defining AXIS_ARB_PKT_CNT_EN.
module axis_frame_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 0
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic                  s0_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  input  logic                  s1_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tid,
  output logic                  busy,
  output logic                  err_oversize
`ifdef AXIS_ARB_PKT_CNT_EN
  ,
  output logic [15:0]           pkt_cnt0,
  output logic [15:0]           pkt_cnt1
`endif
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state, state_next;
  logic                  grant, grant_next;
  logic                  last_grant, last_grant_next;
  logic [15:0]           beat_cnt, beat_cnt_next;
  logic                  slot_ready;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept;
  logic                  force_last;
  logic                  pkt_done;

  assign slot_ready     = !m_axis_tvalid || m_axis_tready;
  assign s0_axis_tready = (state == GRANT) && !grant && slot_ready;
  assign s1_axis_tready = (state == GRANT) &&  grant && slot_ready;
  assign busy           = (state == GRANT);

  assign sel_valid = grant ? s1_axis_tvalid : s0_axis_tvalid;
  assign sel_last  = grant ? s1_axis_tlast  : s0_axis_tlast;
  assign sel_data  = grant ? s1_axis_tdata  : s0_axis_tdata;
  assign accept    = (state == GRANT) && sel_valid && slot_ready;

  // The beat being accepted is number beat_cnt+1 of the current packet.
  assign force_last = (MAX_BEATS > 0) && !sel_last &&
                      (({1'b0, beat_cnt} + 17'd1) == 17'(MAX_BEATS));
  assign pkt_done   = accept && (sel_last || force_last);

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    beat_cnt_next   = beat_cnt;
    case (state)
      IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid) begin
          grant_next = !last_grant;
          state_next = GRANT;
        end else if (s0_axis_tvalid) begin
          grant_next = 1'b0;
          state_next = GRANT;
        end else if (s1_axis_tvalid) begin
          grant_next = 1'b1;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (pkt_done) begin
          state_next      = IDLE;
          last_grant_next = grant;
          beat_cnt_next   = '0;
        end else if (accept) begin
          beat_cnt_next = beat_cnt + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
      beat_cnt   <= beat_cnt_next;
    end
  end

  // Output slice: load on accept, otherwise drain when the IP takes the beat.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= 1'b0;
      err_oversize  <= 1'b0;
    end else begin
      if (accept) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= sel_data;
        m_axis_tlast  <= sel_last || force_last;
        m_axis_tid    <= grant;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (accept && force_last) begin
        err_oversize <= 1'b1;
      end
    end
  end

`ifdef AXIS_ARB_PKT_CNT_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (pkt_done) begin
      if (grant) pkt_cnt1 <= pkt_cnt1 + 16'd1;
      else       pkt_cnt0 <= pkt_cnt0 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed self-checking bench for axis_frame_arbiter (guard enabled with MAX_BEATS=8).
// Source queues feed both slave ports; accepted master beats are logged and compared to hand-built lists.
module tb_axis_frame_arbiter;

  localparam int DW   = 32;
  localparam int MAXB = 8;

  logic          aclk   = 1'b0;
  logic          areset = 1'b1;
  logic [DW-1:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic          s0_axis_tvalid, s0_axis_tready, s0_axis_tlast;
  logic          s1_axis_tvalid, s1_axis_tready, s1_axis_tlast;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tid;
  logic          busy, err_oversize;
`ifdef AXIS_ARB_PKT_CNT_EN
  logic [15:0]   pkt_cnt0, pkt_cnt1;
`endif

  logic [DW:0]   q0[$];
  logic [DW:0]   q1[$];
  logic [DW+1:0] outq[$];
  logic [DW+1:0] expq[$];
  int            errors = 0;
  int            checks = 0;
  int            busy_cycles = 0;
  bit            rand_ready = 1'b0;

  always #5 aclk = ~aclk;

  axis_frame_arbiter #(.DATA_WIDTH(DW), .MAX_BEATS(MAXB)) u_dut (
    .aclk(aclk),
    .areset(areset),
`ifdef AXIS_ARB_PKT_CNT_EN
    .pkt_cnt0(pkt_cnt0),
    .pkt_cnt1(pkt_cnt1),
`endif
    .s0_axis_tdata(s0_axis_tdata),
    .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tready(s0_axis_tready),
    .s0_axis_tlast(s0_axis_tlast),
    .s1_axis_tdata(s1_axis_tdata),
    .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tready(s1_axis_tready),
    .s1_axis_tlast(s1_axis_tlast),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tid(m_axis_tid),
    .busy(busy),
    .err_oversize(err_oversize)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic addPkt(input int src, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      if (src == 0) q0.push_back({(i == n - 1), DW'(base + i)});
      else          q1.push_back({(i == n - 1), DW'(base + i)});
    end
  endtask

  task automatic pushExp(input logic tid, input logic last, input int data);
    expq.push_back({tid, last, DW'(data)});
  endtask

  // Reset is applied and released 2 time units after a falling edge, away from both clock edges.
  task automatic applyReset();
    @(negedge aclk);
    #2 areset = 1'b1;
    q0.delete();
    q1.delete();
    rand_ready    = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(negedge aclk);
    outq.delete();
    expq.delete();
  endtask

  task automatic applyStimulus();
    #2 areset = 1'b0;
    busy_cycles = 0;
  endtask

  task automatic waitDrain(input int max_cycles);
    bit done;
    done = 1'b0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      @(negedge aclk);
      if (q0.size() == 0 && q1.size() == 0 && !m_axis_tvalid) done = 1'b1;
    end
    if (!done) checkOutput("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic compareStream(input string name);
    checkOutput({name, "_beats"}, 64'(outq.size()), 64'(expq.size()));
    for (int i = 0; i < outq.size() && i < expq.size(); i++)
      checkOutput($sformatf("%s_beat%0d", name, i), 64'(outq[i]), 64'(expq[i]));
  endtask

  // Source and sink model: decide handshakes at the falling edge, update queues just after the rising edge.
  initial begin
    logic          take0, take1, hold_pend;
    logic [DW+1:0] hold_val;
    s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0; s0_axis_tdata = '0;
    s1_axis_tvalid = 1'b0; s1_axis_tlast = 1'b0; s1_axis_tdata = '0;
    m_axis_tready  = 1'b1;
    hold_pend      = 1'b0;
    hold_val       = '0;
    forever begin
      @(negedge aclk);
      take0 = s0_axis_tvalid && s0_axis_tready;
      take1 = s1_axis_tvalid && s1_axis_tready;
      if (busy) busy_cycles++;
      if (!areset && hold_pend)
        checkOutput("hold_stable", 64'({m_axis_tvalid, m_axis_tid, m_axis_tlast, m_axis_tdata}),
                    64'({1'b1, hold_val}));
      hold_pend = m_axis_tvalid && !m_axis_tready && !areset;
      hold_val  = {m_axis_tid, m_axis_tlast, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready) outq.push_back({m_axis_tid, m_axis_tlast, m_axis_tdata});
      @(posedge aclk);
      #1;
      if (!areset) begin
        if (take0 && q0.size() > 0) void'(q0.pop_front());
        if (take1 && q1.size() > 0) void'(q1.pop_front());
      end
      s0_axis_tvalid = (q0.size() > 0);
      {s0_axis_tlast, s0_axis_tdata} = (q0.size() > 0) ? q0[0] : '0;
      s1_axis_tvalid = (q1.size() > 0);
      {s1_axis_tlast, s1_axis_tdata} = (q1.size() > 0) ? q1[0] : '0;
      if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values and a single 4-beat packet from source 0.
    applyReset();
    checkOutput("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    checkOutput("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
    checkOutput("rst_m_tid", 64'(m_axis_tid), 64'd0);
    checkOutput("rst_s0_tready", 64'(s0_axis_tready), 64'd0);
    checkOutput("rst_s1_tready", 64'(s1_axis_tready), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_err", 64'(err_oversize), 64'd0);
    addPkt(0, 1, 4);
    applyStimulus();
    waitDrain(60);
    for (int i = 1; i <= 4; i++) pushExp(1'b0, (i == 4), i);
    compareStream("single");
    checkOutput("single_busy_cycles", 64'(busy_cycles), 64'd4);
    checkOutput("single_err", 64'(err_oversize), 64'd0);

    // Both sources valid from reset: packets alternate s0, s1, s0, s1.
    applyReset();
    addPkt(0, 'h10, 3); addPkt(0, 'h13, 3);
    addPkt(1, 'h20, 3); addPkt(1, 'h23, 3);
    applyStimulus();
    waitDrain(120);
    for (int i = 0; i < 3; i++) pushExp(1'b0, (i == 2), 'h10 + i);
    for (int i = 0; i < 3; i++) pushExp(1'b1, (i == 2), 'h20 + i);
    for (int i = 0; i < 3; i++) pushExp(1'b0, (i == 2), 'h13 + i);
    for (int i = 0; i < 3; i++) pushExp(1'b1, (i == 2), 'h23 + i);
    compareStream("rr");
`ifdef AXIS_ARB_PKT_CNT_EN
    checkOutput("rr_pkt_cnt0", 64'(pkt_cnt0), 64'd2);
    checkOutput("rr_pkt_cnt1", 64'(pkt_cnt1), 64'd2);
`endif

    // 20-beat packet with random backpressure; the 8-beat guard splits it at beats 8 and 16.
    applyReset();
    addPkt(0, 1, 20);
    rand_ready = 1'b1;
    applyStimulus();
    waitDrain(500);
    for (int i = 1; i <= 20; i++) pushExp(1'b0, (i == 8 || i == 16 || i == 20), i);
    compareStream("stall");
    checkOutput("stall_err", 64'(err_oversize), 64'd1);

    // Exactly MAX_BEATS with tlast is legal; 10 beats from s1 are cut at 8 and flag an error.
    applyReset();
    addPkt(0, 'h61, 8);
    applyStimulus();
    waitDrain(60);
    for (int i = 0; i < 8; i++) pushExp(1'b0, (i == 7), 'h61 + i);
    compareStream("exact8");
    checkOutput("exact8_err", 64'(err_oversize), 64'd0);
    outq.delete();
    expq.delete();
    addPkt(1, 'h31, 10);
    waitDrain(80);
    for (int i = 0; i < 10; i++) pushExp(1'b1, (i == 7 || i == 9), 'h31 + i);
    compareStream("guard");
    checkOutput("guard_err", 64'(err_oversize), 64'd1);

    // Reset while beat 3 of 6 is on the master port, then a fresh tie goes to s0.
    applyReset();
    addPkt(0, 'h71, 6);
    applyStimulus();
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge aclk);
        if (m_axis_tvalid && m_axis_tdata == DW'('h73)) seen = 1'b1;
      end
      checkOutput("midrst_reached_beat3", 64'(seen), 64'd1);
    end
    #2 areset = 1'b1;
    #1;
    checkOutput("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_s0_tready", 64'(s0_axis_tready), 64'd0);
    q0.delete();
    q1.delete();
    repeat (2) @(negedge aclk);
    outq.delete();
    expq.delete();
    addPkt(1, 'h51, 2);
    addPkt(0, 'h41, 2);
    repeat (2) @(negedge aclk);
    applyStimulus();
    waitDrain(60);
    pushExp(1'b0, 1'b0, 'h41); pushExp(1'b0, 1'b1, 'h42);
    pushExp(1'b1, 1'b0, 'h51); pushExp(1'b1, 1'b1, 'h52);
    compareStream("postrst");
    checkOutput("postrst_err", 64'(err_oversize), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
